// File: rtl/alu_fpga_pkg.sv
// Shared types and constants for the DE2 ALU front-panel controller.
// Holds the FSM state encoding and the active-low seven-segment hex table.
package alu_fpga_pkg;

    typedef enum logic [2:0] {
        S_OP1,
        S_OP2,
        S_OPC,
        S_EXEC,
        S_RES
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0, segments g..a, active low
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/alu_fpga_ctrl_key_cond.sv
// Pushbutton conditioner: 2-flop sync, optional debounce (ALU_FPGA_DEBOUNCE_EN), rising-edge pulse.
// Latency: pulse <=3 cycles after press, DEBOUNCE_CYC+3 with debounce enabled.
// Backpressure: none; a held key yields one pulse, release re-arms it.
module key_cond #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync0;
    logic sync1;
    logic lvl;
    logic acc;
    logic acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            acc_d <= 1'b0;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
            acc_d <= acc;
        end
    end

    assign lvl = ~sync1;

`ifdef ALU_FPGA_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt;
    logic          raw_q;

    // Any change of the synchronised level restarts the stability window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            raw_q <= 1'b0;
            acc   <= 1'b0;
        end else if (lvl != raw_q) begin
            raw_q <= lvl;
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            acc   <= raw_q;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
`else
    localparam int DEB_CYC_UNUSED = DEBOUNCE_CYC;
    assign acc = lvl;
`endif

    assign press = acc & ~acc_d;

endmodule

// File: rtl/alu_fpga_ctrl.sv
// DE2 front-panel controller: key-sequenced operand/opcode entry, ALU result capture, paged hex display.
// Latency: press pulse moves state on the same edge; result captured one cycle after opcode commit; HEX registered.
// Backpressure: none; ALU assumed to settle within one cycle. Debounce via ALU_FPGA_DEBOUNCE_EN.
module alu_fpga_ctrl
    import alu_fpga_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NDIGITS      = 8,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                   CLOCK_50,
    input  logic                   RST,
    input  logic [3:0]             KEY,
    input  logic [17:0]            SW,
    output logic [DATA_W-1:0]      op1,
    output logic [DATA_W-1:0]      op2,
    output logic [3:0]             opcode,
    input  logic [DATA_W-1:0]      res,
    input  logic                   flag_z,
    input  logic                   flag_n,
    input  logic                   flag_v,
    output logic [7*NDIGITS-1:0]   HEX,
    output logic [3:0]             LEDG
);

    localparam bit PAGED = (DATA_W > 4 * NDIGITS);
    localparam int NNIB  = (DATA_W + 3) / 4;
    localparam int PAD_W = 4 * NNIB;

    state_t state;
    state_t state_nxt;

    logic [2:0] press;
    logic       commit;
    logic       abort;
    logic       page_key;

    logic       ld_op1;
    logic       ld_op2;
    logic       ld_opc;
    logic       cap_res;
    logic       clr_vld;

    logic [DATA_W-1:0]    entry;
    logic [DATA_W-1:0]    res_q;
    logic [2:0]           flags_q;
    logic                 vld_q;
    logic                 page_q;
    logic [DATA_W-1:0]    disp;
    logic [PAD_W-1:0]     disp_pad;
    logic [7*NDIGITS-1:0] hex_nxt;
    logic [7*NDIGITS-1:0] hex_q;
    int                   idx;

    logic unused_ok;
    assign unused_ok = &{1'b0, KEY[3], SW[17]};

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_cond #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_key (
            .clk   (CLOCK_50),
            .rst   (RST),
            .key_n (KEY[k]),
            .press (press[k])
        );
    end

    assign commit   = press[0];
    assign abort    = press[1];
    assign page_key = press[2];

    assign entry = DATA_W'($signed(SW[16:0]));

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state <= S_OP1;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks commit everywhere except the single EXEC cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_EXEC: state_nxt = S_RES;
            default: begin
                if (abort) begin
                    state_nxt = S_OP1;
                end else if (commit) begin
                    case (state)
                        S_OP1:   state_nxt = S_OP2;
                        S_OP2:   state_nxt = S_OPC;
                        S_OPC:   state_nxt = S_EXEC;
                        default: state_nxt = S_OP1;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        ld_op1  = 1'b0;
        ld_op2  = 1'b0;
        ld_opc  = 1'b0;
        cap_res = 1'b0;
        clr_vld = 1'b0;
        case (state)
            S_OP1:   ld_op1  = commit & ~abort;
            S_OP2:   ld_op2  = commit & ~abort;
            S_OPC:   ld_opc  = commit & ~abort;
            S_EXEC:  cap_res = 1'b1;
            S_RES:   clr_vld = commit;
            default: ;
        endcase
        if (abort && state != S_EXEC) begin
            clr_vld = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            op1     <= '0;
            op2     <= '0;
            opcode  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            if (ld_op1) op1    <= entry;
            if (ld_op2) op2    <= entry;
            if (ld_opc) opcode <= SW[3:0];
            if (cap_res) begin
                res_q   <= res;
                flags_q <= {flag_v, flag_n, flag_z};
                vld_q   <= 1'b1;
            end else if (clr_vld) begin
                vld_q   <= 1'b0;
            end
        end
    end

    // Page only matters when the value is wider than the display
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            page_q <= 1'b0;
        end else if (state_nxt != state) begin
            page_q <= 1'b0;
        end else if (PAGED && page_key) begin
            page_q <= ~page_q;
        end
    end

    assign disp     = (state == S_RES) ? res_q : entry;
    assign disp_pad = PAD_W'(disp);

    always_comb begin
        hex_nxt = {NDIGITS{SEG_BLANK}};
        idx     = 0;
        for (int i = 0; i < NDIGITS; i++) begin
            idx = (page_q ? NDIGITS : 0) + i;
            if (idx < NNIB) begin
                hex_nxt[7*i +: 7] = seg_decode(disp_pad[4*idx +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            hex_q <= {NDIGITS{SEG_BLANK}};
        end else begin
            hex_q <= hex_nxt;
        end
    end

    assign HEX  = hex_q;
    assign LEDG = {vld_q, flags_q};

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
// Directed bench for alu_fpga_ctrl: 4-digit paged instance plus a 10-digit unpaged instance on shared inputs.
// Results captured by the DUT are checked against a queue of expected values pushed at opcode entry.
module tb_alu_fpga_ctrl;
    import alu_fpga_pkg::*;

    localparam int DEB = 10;
`ifdef ALU_FPGA_DEBOUNCE_EN
    localparam int LAT = DEB + 4;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 4;

    logic        CLOCK_50;
    logic        RST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] op1, op2, res;
    logic [3:0]  opcode, LEDG;
    logic        flag_z, flag_n, flag_v;
    logic [27:0] HEX;
    logic [31:0] w_op1, w_op2;
    logic [3:0]  w_opcode, w_ledg;
    logic [69:0] w_hex;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  led;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic vld_prev;
    int   total;
    int   bad;

    alu_fpga_ctrl #(.DATA_W(32), .NDIGITS(4), .DEBOUNCE_CYC(DEB)) u_dut (
        .CLOCK_50 (CLOCK_50), .RST (RST), .KEY (KEY), .SW (SW),
        .op1 (op1), .op2 (op2), .opcode (opcode), .res (res),
        .flag_z (flag_z), .flag_n (flag_n), .flag_v (flag_v),
        .HEX (HEX), .LEDG (LEDG)
    );

    alu_fpga_ctrl #(.DATA_W(32), .NDIGITS(10), .DEBOUNCE_CYC(DEB)) u_wide (
        .CLOCK_50 (CLOCK_50), .RST (RST), .KEY (KEY), .SW (SW),
        .op1 (w_op1), .op2 (w_op2), .opcode (w_opcode), .res (res),
        .flag_z (flag_z), .flag_n (flag_n), .flag_v (flag_v),
        .HEX (w_hex), .LEDG (w_ledg)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Bench-side ALU
    always_comb begin
        case (opcode)
            4'h2:    res = op1 + op2;
            4'h3:    res = op1 - op2;
            4'hF:    res = 32'hDEADBEEF;
            default: res = op1 & op2;
        endcase
        flag_z = (res == 32'h0);
        flag_n = res[31];
        flag_v = (opcode == 4'h2) && (op1[31] == op2[31]) && (res[31] != op1[31]);
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [69:0] hex_exp(input logic [31:0] v, input int pg, input int nd);
        logic [69:0] r;
        int          k;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            k = pg * nd + i;
            if (k < 8) r[7*i +: 7] = seg7(v[4*k +: 4]);
            else       r[7*i +: 7] = 7'h7F;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge CLOCK_50);
        KEY = KEY & ~mask;
        repeat (hold) @(negedge CLOCK_50);
        KEY = KEY | mask;
        repeat (HOLD) @(negedge CLOCK_50);
    endtask

    // Scoreboard: each rising result-valid LED pops one expected capture
    always @(negedge CLOCK_50) begin
        if (!RST && LEDG[3] && !vld_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 70'd1, 70'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_res", u_dut.res_q, e.res);
                chk("sb_led", LEDG, e.led);
            end
        end
        vld_prev <= LEDG[3];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        vld_prev = 1'b0;
        RST      = 1'b1;
        KEY      = 4'hF;
        SW       = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_state", u_dut.state, S_OP1);
        chk("rst_ledg",  LEDG, 4'h0);
        chk("rst_hex",   HEX, {4{7'h7F}});
        chk("rst_whex",  w_hex, {10{7'h7F}});
        chk("rst_op1",   op1, 32'h0);
        chk("rst_opc",   opcode, 4'h0);
        RST = 1'b0;

        // op1 / op2 entry with sign extension; long hold yields a single advance
        SW = 18'h00005;
        press(4'b0001, HOLD);
        chk("op1_val",  op1, 32'h5);
        chk("op1_next", u_dut.state, S_OP2);
        SW = 18'h1FFFD;
        repeat (2) @(negedge CLOCK_50);
        chk("hex_live", HEX, hex_exp(32'hFFFFFFFD, 0, 4));
        press(4'b0001, HOLD);
        chk("op2_sext", op2, 32'hFFFFFFFD);
        chk("op2_next", u_dut.state, S_OPC);

        // Opcode commit with exact capture timing
        SW = 18'h00002;
        sb.push_back('{res: 32'h00000002, led: 4'b1000});
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (LAT) @(negedge CLOCK_50);
        chk("opc_val",   opcode, 4'h2);
        chk("opc_exec",  u_dut.state, S_EXEC);
        chk("opc_novld", LEDG[3], 1'b0);
        @(negedge CLOCK_50);
        chk("res_q",     u_dut.res_q, 32'h2);
        chk("res_ledg",  LEDG, 4'b1000);
        chk("res_state", u_dut.state, S_RES);
        KEY[0] = 1'b1;
        repeat (HOLD) @(negedge CLOCK_50);
        chk("res_hex", HEX, hex_exp(32'h2, 0, 4));

        press(4'b0001, HOLD);
        chk("ret_state", u_dut.state, S_OP1);
        chk("ret_ledg",  LEDG, 4'b0000);
        chk("ret_op1",   op1, 32'h5);
        chk("ret_op2",   op2, 32'hFFFFFFFD);
        chk("ret_opc",   opcode, 4'h2);

        // Commit + abort together in S_OP2
        SW = 18'h00007;
        press(4'b0001, HOLD);
        chk("ab_op1", op1, 32'h7);
        SW = 18'h00009;
        press(4'b0011, HOLD);
        chk("ab_state", u_dut.state, S_OP1);
        chk("ab_op2",   op2, 32'hFFFFFFFD);

        // Paged display of a 32-bit result on 4 digits, unpaged on 10
        SW = 18'h00001;
        press(4'b0001, HOLD);
        press(4'b0001, HOLD);
        SW = 18'h0000F;
        sb.push_back('{res: 32'hDEADBEEF, led: 4'b1010});
        press(4'b0001, HOLD);
        chk("pg_state", u_dut.state, S_RES);
        chk("pg0_hex",  HEX, hex_exp(32'hDEADBEEF, 0, 4));
        chk("w_hex",    w_hex, hex_exp(32'hDEADBEEF, 0, 10));
        chk("w_blank",  w_hex[69:56], 14'h3FFF);
        press(4'b0100, HOLD);
        chk("pg1_hex",  HEX, hex_exp(32'hDEADBEEF, 1, 4));
        chk("w_nopage", w_hex, hex_exp(32'hDEADBEEF, 0, 10));
        chk("pg_hold",  u_dut.state, S_RES);
        press(4'b0001, HOLD);
        chk("pg_ret",   u_dut.state, S_OP1);
        chk("pg_reset", u_dut.page_q, 1'b0);
        chk("pg_hexen", HEX, hex_exp(32'h0000000F, 0, 4));
        chk("pg_ledg",  LEDG, 4'b0010);

        // Asynchronous reset in the middle of S_OPC
        SW = 18'h00003;
        press(4'b0001, HOLD);
        SW = 18'h00004;
        press(4'b0001, HOLD);
        chk("mr_pre", u_dut.state, S_OPC);
        @(negedge CLOCK_50);
        #2 RST = 1'b1;
        #1;
        chk("mr_state", u_dut.state, S_OP1);
        chk("mr_ledg",  LEDG, 4'h0);
        chk("mr_op1",   op1, 32'h0);
        chk("mr_op2",   op2, 32'h0);
        @(negedge CLOCK_50);
        chk("mr_hex",   HEX, {4{7'h7F}});
        RST = 1'b0;
        repeat (2) @(negedge CLOCK_50);

`ifdef ALU_FPGA_DEBOUNCE_EN
        SW = 18'h00011;
        press(4'b0001, 5);
        chk("gl_state", u_dut.state, S_OP1);
        chk("gl_op1",   op1, 32'h0);
        press(4'b0001, 20);
        chk("db_state", u_dut.state, S_OP2);
        chk("db_op1",   op1, 32'h11);
`endif

        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
